// File: rtl/serial_pkg.sv
// Shared definitions for the 8-bit address / 8-bit data serial link master.
package serial_pkg;

    // Frame sequencing: address bits out, data bits in, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_PH = 2'd1,
        DATA_PH = 2'd2,
        FIN     = 2'd3
    } state_t;

    // Total SCLK rising edges per frame; the slave's 4-bit edge counter relies on it.
    localparam int FRAME_BITS  = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;

    // Smallest divider that still gives a distinct last-high-phase cycle.
    localparam int MIN_CLK_DIV = 2;

endpackage

// File: rtl/sclk_gen.sv
// SCLK divider: walks a low phase then a high phase of CLK_DIV cycles each
// and flags the cycles on which the master must change SCLK or sample RX.
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick,
    output logic o_sample_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_lastCnt;

    assign w_lastCnt = (r_cnt == LAST_CNT);

    // Ticks fire on the last cycle of a phase so the registered SCLK in the
    // top changes exactly at the phase boundary. The last high-phase cycle is
    // both the RX sampling point and the cycle before SCLK falls.
    assign o_rise_tick   = i_en & w_lastCnt & ~r_phase;
    assign o_fall_tick   = i_en & w_lastCnt &  r_phase;
    assign o_sample_tick = i_en & w_lastCnt &  r_phase;

    // Divider counter and phase; parked at the start of a low phase when idle
    // so every frame begins with a full-length low phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_lastCnt) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_master_ctrl.sv
// Serial link master: shifts an address out LSB-first, reads data back
// LSB-first, and reports completion with a one-cycle DONE pulse.
module serial_master_ctrl
    import serial_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sclk,
    output logic              o_tx,
    input  logic              i_rx
);

    localparam int DIV       = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int BIT_CNT_W = $clog2(FRAME_LEN);
    localparam logic [BIT_CNT_W-1:0] LAST_ADDR_BIT  = BIT_CNT_W'(ADDR_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_FRAME_BIT = BIT_CNT_W'(FRAME_LEN - 1);

    state_t              r_state;
    logic [BIT_CNT_W-1:0] r_bitCnt;
    logic [ADDR_W-2:0]   r_addrRest;
    logic [DATA_W-2:0]   r_shift;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_tx;
    logic [DATA_W-1:0]   r_data;

    logic                w_riseTick;
    logic                w_fallTick;
    logic                w_sampleTick;
    logic [DATA_W-1:0]   w_shiftNext;

    sclk_gen #(
        .CLK_DIV (DIV)
    ) u_sclk_gen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (r_busy),
        .o_rise_tick   (w_riseTick),
        .o_fall_tick   (w_fallTick),
        .o_sample_tick (w_sampleTick)
    );

    // RX enters at the top so the first data bit ends up in bit 0 once all
    // DATA_W bits have been shifted in.
    assign w_shiftNext = {i_rx, r_shift};

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_data = r_data;
    assign o_sclk = r_sclk;
    assign o_tx   = r_tx;

    // Frame FSM with all outputs registered; TX only moves on a fall tick,
    // i.e. at a bit boundary while SCLK is going low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_addrRest <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_tx       <= 1'b0;
            r_data     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= ADDR_PH;
                        r_busy     <= 1'b1;
                        r_bitCnt   <= '0;
                        r_tx       <= i_addr[0];
                        r_addrRest <= i_addr[ADDR_W-1:1];
                    end
                end
                ADDR_PH, DATA_PH: begin
                    if (w_riseTick) begin
                        r_sclk <= 1'b1;
                    end
                    if (w_sampleTick && (r_state == DATA_PH)) begin
                        r_shift <= w_shiftNext[DATA_W-1:1];
                    end
                    if (w_fallTick) begin
                        r_sclk   <= 1'b0;
                        r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
                        if (r_state == ADDR_PH) begin
                            r_addrRest <= r_addrRest >> 1;
                            if (r_bitCnt == LAST_ADDR_BIT) begin
                                r_state <= DATA_PH;
                                r_tx    <= 1'b0;
                            end else begin
                                r_tx    <= r_addrRest[0];
                            end
                        end else if (r_bitCnt == LAST_FRAME_BIT) begin
                            r_state  <= FIN;
                            r_bitCnt <= '0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_data   <= w_shiftNext;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_master_ctrl.sv
// Directed bench for serial_master_ctrl with a behavioural slave model
// (address 8'hA5, data 8'h3C) on the CLK_DIV = 2 instance and a second
// instance at CLK_DIV = 5 for divider timing.
module tb_serial_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] addr;
    logic       busy, done, sclk, tx, rx;
    logic [7:0] data;

    logic       start5;
    logic [7:0] addr5;
    logic       busy5, done5, sclk5, tx5;
    logic       rx5 = 1'b0;
    logic [7:0] data5;

    int vectors     = 0;
    int miscompares = 0;

    // Frame observation results filled by applyStimulus
    int         doneAt, doneCnt, rises, firstRiseAt;
    logic       busyAt1, txAt1, sclkAt1, busyAt67;
    logic [7:0] txBits, dataAtDone, dataAt64;

    // Behavioural slave state
    logic       slaveRst = 1'b0;
    logic [3:0] slvCnt;
    logic [7:0] slvShift, slvAddr;
    logic [7:0] slvMyAddr = 8'hA5;
    logic [7:0] slvData   = 8'h3C;

    always #5 clk = ~clk;

    serial_master_ctrl #(.CLK_DIV(2), .ADDR_W(8), .DATA_W(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_addr  (addr),
        .o_busy  (busy),
        .o_done  (done),
        .o_data  (data),
        .o_sclk  (sclk),
        .o_tx    (tx),
        .i_rx    (rx)
    );

    serial_master_ctrl #(.CLK_DIV(5), .ADDR_W(8), .DATA_W(8)) dutDiv5 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start5),
        .i_addr  (addr5),
        .o_busy  (busy5),
        .o_done  (done5),
        .o_data  (data5),
        .o_sclk  (sclk5),
        .o_tx    (tx5),
        .i_rx    (rx5)
    );

    // Slave: edges 0..7 capture TX LSB-first, edges 8..15 drive data bits
    // when the captured address matches, otherwise RX stays pulled low.
    always @(posedge sclk or posedge slaveRst) begin
        if (slaveRst) begin
            slvCnt   <= 4'd0;
            slvShift <= 8'h00;
            slvAddr  <= 8'h00;
            rx       <= 1'b0;
        end else begin
            slvCnt <= slvCnt + 4'd1;
            if (!slvCnt[3]) begin
                slvShift <= {tx, slvShift[7:1]};
                rx       <= 1'b0;
                if (slvCnt == 4'd7) slvAddr <= {tx, slvShift[7:1]};
            end else begin
                rx <= (slvAddr == slvMyAddr) ? slvData[slvCnt[2:0]] : 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic resetSlave();
        slaveRst = 1'b1;
        #1;
        slaveRst = 1'b0;
    endtask

    // mode 0: single START pulse; mode 1: extra START pulses at cycles 10/40;
    // mode 2: START held high. ADDR is changed at cycle 20 in every mode.
    task automatic applyStimulus(input logic [7:0] a, input int mode, input int nCycles);
        logic prevSclk;
        doneAt = -1; doneCnt = 0; rises = 0; firstRiseAt = -1;
        txBits = 8'h00; dataAtDone = 8'hxx; dataAt64 = 8'hxx;
        busyAt1 = 1'b0; txAt1 = 1'b0; sclkAt1 = 1'b1; busyAt67 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        prevSclk = sclk;
        for (int c = 1; c <= nCycles; c++) begin
            @(negedge clk);
            case (mode)
                1:       start = (c == 10) || (c == 40);
                2:       start = 1'b1;
                default: start = 1'b0;
            endcase
            if (c == 20) addr = (mode == 2) ? 8'h5A : ~a;
            if (c == 1) begin
                busyAt1 = busy;
                txAt1   = tx;
                sclkAt1 = sclk;
            end
            if (sclk && !prevSclk) begin
                rises++;
                if (rises == 1) firstRiseAt = c;
                if (rises <= 8) txBits[3'(rises - 1)] = tx;
            end
            prevSclk = sclk;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt     = c;
                    dataAtDone = data;
                end
            end
            if (c == 64) dataAt64 = data;
            if (c == 67) busyAt67 = busy;
        end
        start = 1'b0;
    endtask

    initial begin
        int  dones;
        bit  found;
        int  edges, badHalf, done5At, lastChange;
        logic prev5;

        rst = 1'b0; start = 1'b0; addr = 8'h00; start5 = 1'b0; addr5 = 8'h00;
        #1 rst = 1'b1;
        resetSlave();
        #1;
        checkOutput("por_busy", busy, 1'b0);
        checkOutput("por_done", done, 1'b0);
        checkOutput("por_sclk", sclk, 1'b0);
        checkOutput("por_tx",   tx,   1'b0);
        checkOutput("por_data", data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] matched read A5");
        applyStimulus(8'hA5, 0, 80);
        checkOutput("m_busy_c1",   busyAt1, 1'b1);
        checkOutput("m_tx_c1",     txAt1, 1'b1);
        checkOutput("m_sclk_c1",   sclkAt1, 1'b0);
        checkOutput("m_rise1_at",  firstRiseAt, 3);
        checkOutput("m_tx_bits",   txBits, 8'hA5);
        checkOutput("m_rises",     rises, 16);
        checkOutput("m_done_at",   doneAt, 65);
        checkOutput("m_done_cnt",  doneCnt, 1);
        checkOutput("m_data",      dataAtDone, 8'h3C);
        checkOutput("m_slv_addr",  slvAddr, 8'hA5);

        $display("[TB] mismatched read 5A");
        applyStimulus(8'h5A, 0, 80);
        checkOutput("mm_data_held", dataAt64, 8'h3C);
        checkOutput("mm_done_at",   doneAt, 65);
        checkOutput("mm_data",      dataAtDone, 8'h00);
        checkOutput("mm_tx_bits",   txBits, 8'h5A);
        checkOutput("mm_slv_addr",  slvAddr, 8'h5A);

        $display("[TB] START pulses during frame");
        applyStimulus(8'hA5, 1, 80);
        checkOutput("hs_done_at",  doneAt, 65);
        checkOutput("hs_done_cnt", doneCnt, 1);
        checkOutput("hs_rises",    rises, 16);
        checkOutput("hs_tx_bits",  txBits, 8'hA5);
        checkOutput("hs_data",     dataAtDone, 8'h3C);

        $display("[TB] START held high");
        applyStimulus(8'hA5, 2, 68);
        checkOutput("hold_done_at", doneAt, 65);
        checkOutput("hold_data",    dataAtDone, 8'h3C);
        checkOutput("hold_busy67",  busyAt67, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 120 && !found; c++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                checkOutput("hold2_data", data, 8'h00);
            end
        end
        checkOutput("hold2_done_seen", found, 1'b1);
        checkOutput("hold2_slv_addr",  slvAddr, 8'h5A);

        $display("[TB] reset during address bit 5");
        @(negedge clk);
        start = 1'b1; addr = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        checkOutput("rst_pre_busy", busy, 1'b1);
        checkOutput("rst_pre_tx",   tx, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_sclk", sclk, 1'b0);
        checkOutput("rst_tx",   tx, 1'b0);
        checkOutput("rst_data", data, 8'h00);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("rst_no_done", dones, 0);
        resetSlave();
        applyStimulus(8'hA5, 0, 80);
        checkOutput("rr_done_at", doneAt, 65);
        checkOutput("rr_rises",   rises, 16);
        checkOutput("rr_data",    dataAtDone, 8'h3C);

        $display("[TB] CLK_DIV = 5 timing");
        @(negedge clk);
        start5 = 1'b1; addr5 = 8'hC3;
        prev5 = sclk5; lastChange = 1; edges = 0; badHalf = 0; done5At = -1;
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            start5 = 1'b0;
            if (sclk5 !== prev5) begin
                edges++;
                if (c - lastChange != 5) badHalf++;
                lastChange = c;
                prev5 = sclk5;
            end
            if (done5 && done5At < 0) done5At = c;
        end
        checkOutput("d5_edges",    edges, 32);
        checkOutput("d5_bad_half", badHalf, 0);
        checkOutput("d5_done_at",  done5At, 161);
        checkOutput("d5_data",     data5, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_master_ctrl.md
# serial_master_ctrl

Synthesizable, system-clocked master for the team's 8-bit address / 8-bit data serial link. It sits directly upstream of `slave_device`: it generates the serial clock, shifts the 8-bit address out LSB-first and reads 8 data bits back LSB-first. It offers a single-cycle START / DONE handshake to the local host logic. It replaces the delay-based behavioural master for synthesis and cycle-accurate benches.

## Interface
- `CLK_DIV`, default 4: system cycles per SCLK half-period. Legal values are 2 and above.
- `ADDR_W`, default 8: address bits per frame.
- `DATA_W`, default 8: data bits per frame.

- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  transaction request; sampled only in IDLE.
- `ADDR`  in  ADDR_W  target address; latched on the cycle START is accepted.
- `BUSY`  out  1  high while a frame is in progress.
- `DONE`  out  1  one-cycle pulse when DATA is valid.
- `DATA`  out  DATA_W  last received data; held until the next DONE.
- `SCLK`  out  1  serial clock to the slave.
- `TX`  out  1  serial data to the slave.
- `RX`  in  1  serial data from the slave.

## Operation
- States:
  - IDLE -> ADDR_PH on START.
  - ADDR_PH -> DATA_PH after ADDR_W bits.
  - DATA_PH -> FIN after DATA_W bits.
  - FIN -> IDLE unconditionally.
- Each bit has a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
- A frame is exactly ADDR_W+DATA_W = 16 SCLK rising edges. This keeps the slave's 4-bit edge counter aligned frame to frame.
- ADDR_PH, bit k:
  - TX = latched ADDR[k] for the whole bit (low and high phase).
  - The slave samples TX on the SCLK rising edge.
- DATA_PH, bit j:
  - TX is held at 0.
  - RX is sampled into shift register bit j on the last cycle of the high phase, immediately before SCLK falls.
- FIN:
  - DATA <= shift register.
  - DONE = 1, BUSY = 0, SCLK = 0, TX = 0.
  - START is ignored in FIN.
- START while BUSY is ignored; ADDR changes while BUSY have no effect.
- A held START produces back-to-back frames. Each new frame begins on the first IDLE cycle after FIN.
- No address-match feedback exists. A non-responding slave yields whatever RX carries; with RX pulled low, DATA = 0.

## Timing
- Reset (async, immediate):
  - State = IDLE.
  - SCLK = 0, TX = 0, BUSY = 0, DONE = 0, DATA = 0.
  - Shift register and counters = 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Cycle 0 is START sampled high in IDLE.
  - Cycle 1: BUSY = 1, SCLK = 0, TX = ADDR[0].
  - Bit k starts at cycle 1 + 2·k·CLK_DIV.
  - SCLK of bit k rises at cycle 1 + (2k+1)·CLK_DIV.
  - The final high phase ends at cycle 32·CLK_DIV.
  - FIN (DONE pulse) occurs at cycle 32·CLK_DIV + 1, i.e. 65 cycles for CLK_DIV = 2.
- TX changes only at bit boundaries, while SCLK is low.
- The divider counter counts 0..CLK_DIV-1 and is $clog2(CLK_DIV) bits wide. The bit counter is 4 bits, counting 0..15, and wraps to 0 at FIN.
- Reset mid-frame:
  - Aborts the frame with no DONE.
  - The slave edge counter is then misaligned. The system must reset or realign the slave before the next START.

## Structure
- Package `serial_pkg` holds:
  - the state enum (IDLE, ADDR_PH, DATA_PH, FIN);
  - `FRAME_BITS` = 16 and the default ADDR_W / DATA_W;
  - the minimum CLK_DIV constant.
- Sub-module `sclk_gen` contains the divider. It outputs `rise_tick`, `fall_tick` and `sample_tick` (last high-phase cycle), and is enabled by BUSY. The FSM, shift registers and output registers live in the top.

## Test plan
- Reset: assert RST asynchronously mid-cycle -> SCLK, TX, BUSY, DONE all 0 and DATA = 8'h00 before the next CLK edge.
- Matched read, CLK_DIV = 2, behavioural slave with ADDR = 8'hA5 and DATA = 8'h3C; START with ADDR = 8'hA5:
  - TX bits 1,0,1,0,0,1,0,1 appear on SCLK rises 1–8;
  - exactly 16 SCLK rises occur;
  - DONE is high at cycle 65 only, with DATA = 8'h3C.
- Mismatch: START with ADDR = 8'h5A, RX weakly pulled low -> DONE at cycle 65, DATA = 8'h00. The previous DATA is held until that DONE.
- Handshake: pulse START at cycles 10 and 40 during a frame -> both ignored. Hold START high -> second frame gives BUSY = 1 at cycle 67, and the slave receives the second address correctly.
- Reset mid-frame: RST during address bit 5 -> immediate idle outputs and no DONE. A new START (with slave re-initialised) completes a full 16-edge frame with correct DATA.
- Divider: CLK_DIV = 5 -> every SCLK half-period is 5 cycles and DONE occurs at cycle 161.
